// File: rtl/nvdla_csb_cmd_sequencer_if.sv
// ---- nvdla_csb_cmd_sequencer_if : command, CSB and read-result channels | rev 1.0 ----
`default_nettype none

interface nvdla_csb_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdat;
   logic        cmd_write;
   logic        cmd_wait_intr;

   logic        csb_valid;
   logic        csb_ready;
   logic [15:0] csb_addr;
   logic [31:0] csb_wdat;
   logic        csb_write;
   logic        csb_nposted;
   logic        csb_rdata_valid;
   logic [31:0] csb_rdata;
   logic        csb_wr_complete;
   logic        intr;

   logic        rdata_valid;
   logic [31:0] rdata;
   logic        rdata_ready;

   // master = sequencer side, slave = command source / NVDLA / result sink
   modport master (
      input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_wait_intr,
      output cmd_ready,
      output csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
      input  csb_ready, csb_rdata_valid, csb_rdata, csb_wr_complete, intr,
      output rdata_valid, rdata,
      input  rdata_ready
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_wait_intr,
      input  cmd_ready,
      input  csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
      output csb_ready, csb_rdata_valid, csb_rdata, csb_wr_complete, intr,
      input  rdata_valid, rdata,
      output rdata_ready
   );
endinterface

`default_nettype wire

// File: rtl/nvdla_csb_cmd_sequencer.sv
// ---- nvdla_csb_cmd_sequencer : feeds a programmed command list into the NVDLA CSB | rev 1.0 ----
`default_nettype none

module nvdla_csb_cmd_sequencer #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_W      = 20,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  wire logic              clk_i,
   input  wire logic              rst_ni,
   input  wire logic              clear_i,
   input  wire logic              start_i,
   input  wire logic [CNT_W-1:0]  n_cmds_i,
   nvdla_csb_cmd_sequencer_if.master bus,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic [CNT_W-1:0]       cmd_cnt_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      ISSUE     = 3'd2,
      WAIT_RESP = 3'd3,
      OUT       = 3'd4,
      WAIT_INTR = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state, state_next;
   logic [CNT_W-1:0]     n_cmds, cmd_cnt, cnt_inc;
   logic [TIMEOUT_W-1:0] wdog;
   logic                 timeout, intr_seen;
   logic [15:0]          addr;
   logic [31:0]          wdat, rdata;
   logic                 write, wait_intr;

   logic start_run, take_cmd, load_rdata, finish, post, abort, arm_wdog, wdog_hit;

   assign cnt_inc  = cmd_cnt + CNT_W'(1);
   assign wdog_hit = (wdog == WDOG_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      take_cmd   = 1'b0;
      load_rdata = 1'b0;
      finish     = 1'b0;
      post       = 1'b0;
      abort      = 1'b0;
      arm_wdog   = 1'b0;
      case (state)
         IDLE: if (start_i) begin
            start_run  = 1'b1;
            state_next = (n_cmds_i != '0) ? FETCH : DONE;
         end
         FETCH: if (bus.cmd_valid) begin
            take_cmd   = 1'b1;
            state_next = ISSUE;
         end
         ISSUE: if (bus.csb_ready) begin
            arm_wdog   = 1'b1;
            state_next = WAIT_RESP;
         end
         // a completion arriving on the limit cycle beats the watchdog
         WAIT_RESP: begin
            if (write ? bus.csb_wr_complete : bus.csb_rdata_valid) begin
               if (write) begin
                  finish = 1'b1;
               end else begin
                  load_rdata = 1'b1;
                  state_next = OUT;
               end
            end else if (wdog_hit) begin
               abort = 1'b1;
            end
         end
         OUT: if (bus.rdata_ready) finish = 1'b1;
         WAIT_INTR: begin
            if (bus.intr || intr_seen) post  = 1'b1;
            else if (wdog_hit)         abort = 1'b1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (finish) begin
         if (wait_intr) begin
            arm_wdog   = 1'b1;
            state_next = WAIT_INTR;
         end else begin
            post = 1'b1;
         end
      end
      if (post)    state_next = (cnt_inc == n_cmds) ? DONE : FETCH;
      if (abort)   state_next = DONE;
      if (clear_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_cmds    <= '0;
         cmd_cnt   <= '0;
         timeout   <= 1'b0;
         intr_seen <= 1'b0;
         wdog      <= '0;
         addr      <= '0;
         wdat      <= '0;
         write     <= 1'b0;
         wait_intr <= 1'b0;
         rdata     <= '0;
      end else if (clear_i) begin
         cmd_cnt   <= '0;
         timeout   <= 1'b0;
         intr_seen <= 1'b0;
      end else begin
         if (start_run) begin
            n_cmds  <= n_cmds_i;
            cmd_cnt <= '0;
            timeout <= 1'b0;
         end
         if (post)  cmd_cnt <= cnt_inc;
         if (abort) timeout <= 1'b1;
         if (take_cmd) begin
            addr      <= bus.cmd_addr;
            wdat      <= bus.cmd_wdat;
            write     <= bus.cmd_write;
            wait_intr <= bus.cmd_wait_intr;
         end
         if (load_rdata) rdata <= bus.csb_rdata;
         if (arm_wdog)
            wdog <= '0;
         else if (state == WAIT_RESP || state == WAIT_INTR)
            wdog <= wdog + TIMEOUT_W'(1);
         // an interrupt seen before WAIT_INTR is remembered so it cannot be missed
         if (start_run || (state == WAIT_INTR && state_next != WAIT_INTR))
            intr_seen <= 1'b0;
         else if (state != IDLE && bus.intr)
            intr_seen <= 1'b1;
      end
   end

   assign bus.cmd_ready   = (state == FETCH);
   assign bus.csb_valid   = (state == ISSUE);
   assign bus.csb_addr    = addr;
   assign bus.csb_wdat    = wdat;
   assign bus.csb_write   = write;
   assign bus.csb_nposted = 1'b1;
   assign bus.rdata_valid = (state == OUT);
   assign bus.rdata       = rdata;

   assign busy_o    = (state != IDLE);
   assign done_o    = (state == DONE);
   assign timeout_o = timeout;
   assign cmd_cnt_o = cmd_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nvdla_csb_cmd_sequencer.sv
// ---- tb_nvdla_csb_cmd_sequencer : directed self-checking bench | rev 1.0 ----
`default_nettype none

module tb_nvdla_csb_cmd_sequencer;
   logic        clk = 1'b0;
   logic        rst_ni, clear_i, start_i;
   logic [15:0] n_cmds_i;
   logic        busy, done, timeout;
   logic [15:0] cmd_cnt;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   nvdla_csb_cmd_sequencer_if ifc ();

   nvdla_csb_cmd_sequencer #(
      .CNT_W(16), .TIMEOUT_W(20), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .n_cmds_i(n_cmds_i), .bus(ifc.master), .busy_o(busy), .done_o(done),
      .timeout_o(timeout), .cmd_cnt_o(cmd_cnt)
   );

   int          hs_total = 0;
   int          done_total = 0;
   int          rx_total = 0;
   logic [15:0] hs_addr_q[$];

   always @(posedge clk) begin
      if (ifc.csb_valid && ifc.csb_ready) begin
         hs_total <= hs_total + 1;
         hs_addr_q.push_back(ifc.csb_addr);
      end
      if (done) done_total <= done_total + 1;
      if (ifc.rdata_valid && ifc.rdata_ready) rx_total <= rx_total + 1;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n);
      start_i  = 1'b1;
      n_cmds_i = n;
      tick();
      start_i  = 1'b0;
   endtask

   task automatic push_cmd(input logic [15:0] a, input logic [31:0] d, input logic w, input logic wi);
      int k;
      k = 0;
      while (ifc.cmd_ready !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      checks++;
      if (ifc.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", ifc.cmd_ready);
      end
      ifc.cmd_valid = 1'b1; ifc.cmd_addr = a; ifc.cmd_wdat = d;
      ifc.cmd_write = w;    ifc.cmd_wait_intr = wi;
      tick();
      ifc.cmd_valid = 1'b0;
   endtask

   task automatic csb_accept();
      int k;
      k = 0;
      while (ifc.csb_valid !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      checks++;
      if (ifc.csb_valid !== 1'b1) begin
         errors++;
         $display("FAIL csb_valid_wait: csb_valid=%b required 1", ifc.csb_valid);
      end
      ifc.csb_ready = 1'b1;
      tick();
      ifc.csb_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; n_cmds_i = '0;
      ifc.cmd_valid = 1'b0; ifc.cmd_addr = '0; ifc.cmd_wdat = '0;
      ifc.cmd_write = 1'b0; ifc.cmd_wait_intr = 1'b0;
      ifc.csb_ready = 1'b0; ifc.csb_rdata_valid = 1'b0; ifc.csb_rdata = '0;
      ifc.csb_wr_complete = 1'b0; ifc.intr = 1'b0; ifc.rdata_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if ({busy, done, timeout, ifc.cmd_ready, ifc.csb_valid, ifc.rdata_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: busy,done,timeout,cmd_ready,csb_valid,rdata_valid=%b required 000000",
                  {busy, done, timeout, ifc.cmd_ready, ifc.csb_valid, ifc.rdata_valid});
      end
      checks++;
      if (ifc.csb_nposted !== 1'b1) begin
         errors++;
         $display("FAIL reset_nposted: csb_nposted=%b required 1", ifc.csb_nposted);
      end
      checks++;
      if ({cmd_cnt, ifc.rdata, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write} !== 97'b0) begin
         errors++;
         $display("FAIL reset_data: cnt=%h rdata=%h addr=%h wdat=%h write=%b required all 0",
                  cmd_cnt, ifc.rdata, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write);
      end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_write();
      int hs0 = hs_total;
      int d0  = done_total;
      start_run(16'd1);
      checks++;
      if (ifc.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_fetch_ready: cmd_ready=%b required 1", ifc.cmd_ready);
      end
      ifc.cmd_valid = 1'b1; ifc.cmd_addr = 16'h0010; ifc.cmd_wdat = 32'hDEADBEEF;
      ifc.cmd_write = 1'b1; ifc.cmd_wait_intr = 1'b0;
      tick();
      ifc.cmd_valid = 1'b0;
      checks++;
      if ({ifc.csb_valid, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write} !== {1'b1, 16'h0010, 32'hDEADBEEF, 1'b1}) begin
         errors++;
         $display("FAIL wr_issue: valid=%b addr=%h wdat=%h write=%b required 1 0010 deadbeef 1",
                  ifc.csb_valid, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write);
      end
      tick();
      tick();
      checks++;
      if ({ifc.csb_valid, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write} !== {1'b1, 16'h0010, 32'hDEADBEEF, 1'b1}) begin
         errors++;
         $display("FAIL wr_issue_stable: valid=%b addr=%h wdat=%h write=%b required 1 0010 deadbeef 1",
                  ifc.csb_valid, ifc.csb_addr, ifc.csb_wdat, ifc.csb_write);
      end
      ifc.csb_ready = 1'b1;
      tick();
      ifc.csb_ready = 1'b0;
      checks++;
      if ({ifc.csb_valid, busy} !== 2'b01) begin
         errors++;
         $display("FAIL wr_wait_resp: csb_valid,busy=%b required 01", {ifc.csb_valid, busy});
      end
      tick();
      tick();
      ifc.csb_wr_complete = 1'b1;
      tick();
      ifc.csb_wr_complete = 1'b0;
      checks++;
      if ({done, cmd_cnt} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL wr_done: done=%b cnt=%0d required done=1 cnt=1", done, cmd_cnt);
      end
      tick();
      checks++;
      if ({done, busy, cmd_cnt} !== {2'b00, 16'd1}) begin
         errors++;
         $display("FAIL wr_idle: done=%b busy=%b cnt=%0d required 0 0 1", done, busy, cmd_cnt);
      end
      checks++;
      if (hs_total - hs0 != 1 || done_total - d0 != 1) begin
         errors++;
         $display("FAIL wr_counts: handshakes=%0d done_pulses=%0d required 1 1", hs_total - hs0, done_total - d0);
      end
   endtask

   task automatic test_read();
      int rx0 = rx_total;
      start_run(16'd1);
      push_cmd(16'h0004, 32'h0, 1'b0, 1'b0);
      csb_accept();
      ifc.csb_rdata_valid = 1'b1; ifc.csb_rdata = 32'h12345678;
      tick();
      ifc.csb_rdata_valid = 1'b0; ifc.csb_rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ifc.rdata_valid !== 1'b1 || ifc.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_hold[%0d]: rdata_valid=%b rdata=%h required 1 12345678", i, ifc.rdata_valid, ifc.rdata);
         end
         // a stray completion while holding the result must be ignored
         if (i == 2) begin
            ifc.csb_rdata_valid = 1'b1; ifc.csb_rdata = 32'hFFFF0000;
         end
         tick();
         ifc.csb_rdata_valid = 1'b0; ifc.csb_rdata = 32'h0;
      end
      ifc.rdata_ready = 1'b1;
      tick();
      ifc.rdata_ready = 1'b0;
      checks++;
      if ({done, ifc.rdata_valid, cmd_cnt, ifc.rdata} !== {2'b10, 16'd1, 32'h12345678}) begin
         errors++;
         $display("FAIL rd_done: done=%b rdata_valid=%b cnt=%0d rdata=%h required 1 0 1 12345678",
                  done, ifc.rdata_valid, cmd_cnt, ifc.rdata);
      end
      checks++;
      if (rx_total - rx0 != 1) begin
         errors++;
         $display("FAIL rd_transfers: transfers=%0d required 1", rx_total - rx0);
      end
      tick();
   endtask

   task automatic test_early_intr();
      start_run(16'd1);
      push_cmd(16'h0020, 32'h00000001, 1'b1, 1'b1);
      csb_accept();
      ifc.intr = 1'b1;
      tick();
      ifc.intr = 1'b0;
      tick();
      ifc.csb_wr_complete = 1'b1;
      tick();
      ifc.csb_wr_complete = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL intr_wait_state: busy,done=%b required 10", {busy, done});
      end
      tick();
      checks++;
      if ({done, timeout, cmd_cnt} !== {2'b10, 16'd1}) begin
         errors++;
         $display("FAIL intr_early_exit: done=%b timeout=%b cnt=%0d required 1 0 1", done, timeout, cmd_cnt);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic stray;
      stray = 1'b0;
      start_run(16'd1);
      push_cmd(16'h0030, 32'h0, 1'b0, 1'b0);
      csb_accept();
      for (int i = 0; i < 15; i++) begin
         if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) stray = 1'b1;
         tick();
      end
      checks++;
      if ({stray, done, timeout} !== 3'b000) begin
         errors++;
         $display("FAIL to_early: stray=%b done=%b timeout=%b required 000", stray, done, timeout);
      end
      tick();
      checks++;
      if ({done, timeout, cmd_cnt} !== {2'b11, 16'd0}) begin
         errors++;
         $display("FAIL to_abort: done=%b timeout=%b cnt=%0d required 1 1 0", done, timeout, cmd_cnt);
      end
      tick();
      checks++;
      if ({done, busy, timeout} !== 3'b001) begin
         errors++;
         $display("FAIL to_sticky: done=%b busy=%b timeout=%b required 0 0 1", done, busy, timeout);
      end
      start_run(16'd1);
      checks++;
      if ({busy, timeout} !== 2'b10) begin
         errors++;
         $display("FAIL to_restart_clears: busy=%b timeout=%b required 1 0", busy, timeout);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int  hs0 = hs_total;
      int  d0  = done_total;
      int  q0  = hs_addr_q.size();
      logic order_ok;
      start_run(16'd3);
      tick();
      tick();
      checks++;
      if ({ifc.cmd_ready, ifc.csb_valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_gap: cmd_ready,csb_valid=%b required 10", {ifc.cmd_ready, ifc.csb_valid});
      end
      push_cmd(16'h0100, 32'h11111111, 1'b1, 1'b0);
      csb_accept();
      start_i = 1'b1; n_cmds_i = 16'd7;
      tick();
      start_i = 1'b0;
      ifc.csb_wr_complete = 1'b1;
      tick();
      ifc.csb_wr_complete = 1'b0;
      checks++;
      if ({ifc.cmd_ready, cmd_cnt} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL b2b_first: cmd_ready=%b cnt=%0d required 1 1", ifc.cmd_ready, cmd_cnt);
      end
      tick();
      push_cmd(16'h0104, 32'h0, 1'b0, 1'b0);
      csb_accept();
      ifc.csb_rdata_valid = 1'b1; ifc.csb_rdata = 32'hA5A5A5A5;
      tick();
      ifc.csb_rdata_valid = 1'b0;
      checks++;
      if ({ifc.rdata_valid, ifc.rdata} !== {1'b1, 32'hA5A5A5A5}) begin
         errors++;
         $display("FAIL b2b_read: rdata_valid=%b rdata=%h required 1 a5a5a5a5", ifc.rdata_valid, ifc.rdata);
      end
      ifc.rdata_ready = 1'b1;
      tick();
      ifc.rdata_ready = 1'b0;
      checks++;
      if ({ifc.cmd_ready, cmd_cnt} !== {1'b1, 16'd2}) begin
         errors++;
         $display("FAIL b2b_second: cmd_ready=%b cnt=%0d required 1 2", ifc.cmd_ready, cmd_cnt);
      end
      push_cmd(16'h0108, 32'h22222222, 1'b1, 1'b0);
      csb_accept();
      ifc.csb_wr_complete = 1'b1;
      tick();
      ifc.csb_wr_complete = 1'b0;
      checks++;
      if ({done, cmd_cnt} !== {1'b1, 16'd3}) begin
         errors++;
         $display("FAIL b2b_done: done=%b cnt=%0d required 1 3", done, cmd_cnt);
      end
      tick();
      order_ok = (hs_addr_q.size() >= q0 + 3) && (hs_addr_q[q0] == 16'h0100) &&
                 (hs_addr_q[q0+1] == 16'h0104) && (hs_addr_q[q0+2] == 16'h0108);
      checks++;
      if (!order_ok || hs_total - hs0 != 3 || done_total - d0 != 1) begin
         errors++;
         $display("FAIL b2b_order: order_ok=%b handshakes=%0d done_pulses=%0d required 1 3 1",
                  order_ok, hs_total - hs0, done_total - d0);
      end
      hs0 = hs_total;
      start_run(16'd0);
      checks++;
      if ({done, busy} !== 2'b11) begin
         errors++;
         $display("FAIL zero_done: done=%b busy=%b required 1 1", done, busy);
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00 || hs_total != hs0) begin
         errors++;
         $display("FAIL zero_idle: done=%b busy=%b handshakes=%0d required 0 0 0", done, busy, hs_total - hs0);
      end
   endtask

   task automatic test_reset_clear();
      int d0 = done_total;
      start_run(16'd1);
      push_cmd(16'h0200, 32'h0, 1'b1, 1'b1);
      checks++;
      if (ifc.csb_valid !== 1'b1) begin
         errors++;
         $display("FAIL rc_issue: csb_valid=%b required 1", ifc.csb_valid);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({ifc.csb_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL rc_async_reset: csb_valid,busy=%b required 00", {ifc.csb_valid, busy});
      end
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      checks++;
      if (done_total != d0 || {busy, cmd_cnt} !== 17'b0) begin
         errors++;
         $display("FAIL rc_after_reset: done_pulses=%0d busy=%b cnt=%0d required 0 0 0", done_total - d0, busy, cmd_cnt);
      end
      start_run(16'd1);
      push_cmd(16'h0204, 32'h00000033, 1'b1, 1'b1);
      csb_accept();
      ifc.csb_wr_complete = 1'b1;
      tick();
      ifc.csb_wr_complete = 1'b0;
      tick();
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL rc_wait_intr: busy,done=%b required 10", {busy, done});
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      checks++;
      if ({busy, done, timeout, cmd_cnt} !== 19'b0) begin
         errors++;
         $display("FAIL rc_clear: busy=%b done=%b timeout=%b cnt=%0d required 0 0 0 0", busy, done, timeout, cmd_cnt);
      end
      tick();
      checks++;
      if (done_total != d0) begin
         errors++;
         $display("FAIL rc_no_done: done_pulses=%0d required 0", done_total - d0);
      end
      start_run(16'd1);
      push_cmd(16'h0208, 32'h0, 1'b0, 1'b0);
      csb_accept();
      ifc.csb_rdata_valid = 1'b1; ifc.csb_rdata = 32'hCAFEF00D;
      tick();
      ifc.csb_rdata_valid = 1'b0;
      ifc.rdata_ready = 1'b1;
      tick();
      ifc.rdata_ready = 1'b0;
      checks++;
      if ({done, cmd_cnt, ifc.rdata} !== {1'b1, 16'd1, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL rc_next_run: done=%b cnt=%0d rdata=%h required 1 1 cafef00d", done, cmd_cnt, ifc.rdata);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_early_intr();
      test_timeout();
      test_back_to_back();
      test_reset_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
